memory_mp_wait: RTL

- Parametrised successor to the two-port (instruction/data) bench memory behind antares_core.
- Generalises to NUM_PORTS independent enable/ready ports sharing one word array.
- Adds per-access wait states, per-port out-of-range error reporting, byte-lane writes, and a defined cross-port collision policy.
- Sits between core/bus masters and storage in benches and FPGA builds.

---
 rtl/memory_mp_pkg.sv | 26 ++
 rtl/memory_mp_wait_if.sv | 27 ++
 rtl/memory_mp_port_ctrl.sv | 76 +++++++
 rtl/memory_mp_wait.sv | 125 ++++++++++++
 4 files changed

// File: rtl/memory_mp_pkg.sv
// Purpose : shared types and sizing helpers for the multi-port wait-state memory.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package memory_mp_pkg;

   localparam int WORD_BYTES = 4;
   localparam int WORD_BITS  = 8 * WORD_BYTES;

   // Per-port access sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } port_state_e;

   // Wait counter only has to hold WAIT_STATES-1; never narrower than 1 bit.
   function automatic int cnt_width(input int wait_states);
      return (wait_states > 2) ? $clog2(wait_states) : 1;
   endfunction

   // Index width for an array of 'words' entries; never narrower than 1 bit.
   function automatic int idx_width(input int words);
      return (words > 2) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/memory_mp_wait_if.sv
// Purpose : flat multi-port request/response bundle between bus masters and the memory.
// Latency : n/a (wires only).
// Backpr. : none; a master holds its request until the matching ready pulse.
// Ports   : addr/din/wr/enable driven by the masters, dout/ready/error driven by the memory;
//           port p occupies slice p of every vector.
interface memory_mp_wait_if #(
   parameter int NUM_PORTS      = 2,
   parameter int MEM_ADDR_WIDTH = 12
);
   logic [NUM_PORTS*MEM_ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS*32-1:0]             din;
   logic [NUM_PORTS*4-1:0]              wr;
   logic [NUM_PORTS-1:0]                enable;
   logic [NUM_PORTS*32-1:0]             dout;
   logic [NUM_PORTS-1:0]                ready;
   logic [NUM_PORTS-1:0]                error;

   modport master (
      output addr, din, wr, enable,
      input  dout, ready, error
   );

   modport slave (
      input  addr, din, wr, enable,
      output dout, ready, error
   );
endinterface

// File: rtl/memory_mp_port_ctrl.sv
// Purpose : one port's IDLE/WAIT/RESP sequencer; flags the edge where the access executes.
// Latency : access edge WAIT_STATES edges after enable is sampled; ready the cycle after.
// Backpr. : none; enable is ignored in WAIT and RESP, so a request always runs to completion.
// Ports   : clk/rst, enable + addr from the master; do_access (access this edge),
//           in_range (addr < MEM_WORDS), ready (RESP cycle).
module memory_mp_port_ctrl
   import memory_mp_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int MEM_WORDS      = 2**MEM_ADDR_WIDTH,
   parameter int WAIT_STATES    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [MEM_ADDR_WIDTH-1:0] addr,
   output logic                      do_access,
   output logic                      in_range,
   output logic                      ready
);

   localparam int CNT_W = cnt_width(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   // One extra bit so MEM_WORDS == 2**MEM_ADDR_WIDTH is representable.
   localparam logic [MEM_ADDR_WIDTH:0] WORDS_LIM = (MEM_ADDR_WIDTH+1)'(MEM_WORDS);

   port_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      do_access = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  state_d   = RESP;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               do_access = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An access edge that coincides with reset is dropped entirely.
      if (rst) begin
         do_access = 1'b0;
      end
   end

   assign in_range = ({1'b0, addr} < WORDS_LIM);
   assign ready    = (state_q == RESP);

endmodule

// File: rtl/memory_mp_wait.sv
// Purpose : NUM_PORTS-port word memory with wait states, byte-lane writes and range errors.
// Latency : ready pulses WAIT_STATES+1 cycles after enable is sampled; dout/error valid with it.
// Backpr. : none; masters hold addr/din/wr until ready, ports never stall each other.
// Ports   : clk, rst (sync, active-high), bus (slave modport of memory_mp_wait_if).
module memory_mp_wait
   import memory_mp_pkg::*;
#(
   parameter int    NUM_PORTS      = 2,
   parameter int    MEM_ADDR_WIDTH = 12,
   parameter int    MEM_WORDS      = 2**MEM_ADDR_WIDTH,
   parameter int    WAIT_STATES    = 0,
   parameter string MEM_INIT_FILE  = ""
) (
   input  logic            clk,
   input  logic            rst,
   memory_mp_wait_if.slave bus
);

   localparam int IDX_W = idx_width(MEM_WORDS);

   logic [WORD_BITS-1:0]      mem_array [MEM_WORDS];

   logic [NUM_PORTS-1:0]      do_access;
   logic [NUM_PORTS-1:0]      in_range;
   logic [NUM_PORTS-1:0]      ready;

   logic [MEM_ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
   logic [IDX_W-1:0]          port_idx  [NUM_PORTS];
   logic [WORD_BITS-1:0]      port_din  [NUM_PORTS];
   logic [WORD_BYTES-1:0]     port_wr   [NUM_PORTS];

   logic [WORD_BYTES-1:0]     lane_req  [NUM_PORTS];
   logic [WORD_BYTES-1:0]     lane_we   [NUM_PORTS];

   logic [WORD_BITS-1:0]      dout_q [NUM_PORTS];
   logic [WORD_BITS-1:0]      dout_d [NUM_PORTS];
   logic [NUM_PORTS-1:0]      error_q, error_d;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign port_addr[p] = bus.addr[p*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      // Only used when in_range is set, so dropping upper address bits is safe.
      assign port_idx[p]  = port_addr[p][IDX_W-1:0];
      assign port_din[p]  = bus.din[p*WORD_BITS +: WORD_BITS];
      assign port_wr[p]   = bus.wr[p*WORD_BYTES +: WORD_BYTES];

      memory_mp_port_ctrl #(
         .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
         .MEM_WORDS      (MEM_WORDS),
         .WAIT_STATES    (WAIT_STATES)
      ) u_ctrl (
         .clk       (clk),
         .rst       (rst),
         .enable    (bus.enable[p]),
         .addr      (port_addr[p]),
         .do_access (do_access[p]),
         .in_range  (in_range[p]),
         .ready     (ready[p])
      );

      assign bus.dout[p*WORD_BITS +: WORD_BITS] = dout_q[p];
   end

   assign bus.ready = ready;
   assign bus.error = error_q;

   // Byte-lane write merge: a lane requested by a lower-index port at the same
   // word masks that lane for every higher-index port. Disjoint lanes all commit.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         lane_req[p] = (do_access[p] && in_range[p]) ? port_wr[p] : '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         lane_we[p] = lane_req[p];
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (q < p && port_addr[q] == port_addr[p]) begin
               lane_we[p] = lane_we[p] & ~lane_req[q];
            end
         end
      end
   end

   // Array is not reset; contents survive rst.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (lane_we[p][b]) begin
               mem_array[port_idx[p]][8*b +: 8] <= port_din[p][8*b +: 8];
            end
         end
      end
   end

   // Reads sample the array before this edge's writes land, giving
   // read-before-write across ports and pre-write data on a write.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         dout_d[p]  = dout_q[p];
         error_d[p] = error_q[p];
         if (do_access[p]) begin
            if (in_range[p]) begin
               dout_d[p]  = mem_array[port_idx[p]];
               error_d[p] = 1'b0;
            end else begin
               dout_d[p]  = '0;
               error_d[p] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            dout_q[p] <= '0;
         end
         error_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            dout_q[p] <= dout_d[p];
         end
         error_q <= error_d;
      end
   end

endmodule
